// File: rtl/status_pkg.sv
// Shared constants, FSM encoding and row-width helper for the instruction
// cache status array (per-way use/valid bits).
package status_pkg;

    localparam int STATUS_BITS   = 2;
    localparam int USE_BIT_IDX   = 0;
    localparam int VALID_BIT_IDX = 1;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Width of one status row: two bits (use, valid) per way.
    function automatic int row_width(input int num_ways);
        return num_ways * STATUS_BITS;
    endfunction

endpackage

// File: rtl/status_array_mem.sv
// Flop-based status storage: DEPTH rows of per-way use/valid pairs, one
// per-way masked write port and one registered read port that carries a
// sideband tag. A common halt freezes writes and the read register.
module status_array_mem
    import status_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int NUM_WAYS   = 4,
    parameter int TAG_WIDTH  = 1,
    parameter int ROW_WIDTH  = row_width(NUM_WAYS)
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  halt,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [TAG_WIDTH-1:0]  rd_tag_in,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [ROW_WIDTH-1:0]  wr_data,
    input  logic [NUM_WAYS-1:0]   wr_mask,
    output logic [ROW_WIDTH-1:0]  rd_data,
    output logic [TAG_WIDTH-1:0]  rd_tag,
    output logic                  rd_valid
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [ROW_WIDTH-1:0] mem [DEPTH];

    // Masked write: only ways with their mask bit set take the new pair.
    always_ff @(posedge clk) begin
        if (wr_en && !halt) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
                if (wr_mask[w]) begin
                    mem[wr_addr][w*STATUS_BITS +: STATUS_BITS] <= wr_data[w*STATUS_BITS +: STATUS_BITS];
                end
            end
        end
    end

    // Registered read port; sees pre-write contents on a same-row collision.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            rd_data  <= '0;
            rd_tag   <= '0;
            rd_valid <= 1'b0;
        end else if (!halt) begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= mem[rd_addr];
                rd_tag  <= rd_tag_in;
            end
        end
    end

endmodule

// File: rtl/status_array_ctrl.sv
// Status array controller: sequential initializer / flush sweep FSM in front
// of the status storage, muxing the write port between the sweep and the
// external requester, and blocking external traffic while sweeping.
module status_array_ctrl
    import status_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int NUM_WAYS   = 4,
    parameter int TAG_WIDTH  = 1,
    parameter int ROW_WIDTH  = row_width(NUM_WAYS)
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  i_halt,
    input  logic                  i_flush,
    input  logic [TAG_WIDTH-1:0]  i_tag,
    input  logic [ADDR_WIDTH-1:0] i_r_addr,
    input  logic                  i_r_valid,
    input  logic [ADDR_WIDTH-1:0] i_w_addr,
    input  logic [ROW_WIDTH-1:0]  i_w_data,
    input  logic [NUM_WAYS-1:0]   i_w_wmask,
    input  logic                  i_w_valid,
    output logic [TAG_WIDTH-1:0]  o_tag,
    output logic [ROW_WIDTH-1:0]  o_data,
    output logic                  o_valid,
    output logic                  o_ready,
    output logic                  o_init_busy
);

    localparam int                  DEPTH    = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ROW = ADDR_WIDTH'(DEPTH - 1);

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   sweep_cnt;

    logic                    mem_wr_en;
    logic [ADDR_WIDTH-1:0]   mem_wr_addr;
    logic [ROW_WIDTH-1:0]    mem_wr_data;
    logic [NUM_WAYS-1:0]     mem_wr_mask;
    logic                    mem_rd_en;

    // Sweep/run FSM with registered ready and busy flags.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state       <= ST_INIT;
            sweep_cnt   <= '0;
            o_ready     <= 1'b0;
            o_init_busy <= 1'b1;
        end else if (!i_halt) begin
            if (state == ST_INIT) begin
                sweep_cnt <= sweep_cnt + ADDR_WIDTH'(1);
                if (sweep_cnt == LAST_ROW) begin
                    state       <= ST_RUN;
                    o_ready     <= 1'b1;
                    o_init_busy <= 1'b0;
                end
            end else if (i_flush) begin
                state       <= ST_INIT;
                sweep_cnt   <= '0;
                o_ready     <= 1'b0;
                o_init_busy <= 1'b1;
            end
        end
    end

    // Write-port mux: the sweep owns the port in INIT; a flush cycle drops
    // any external write.
    always_comb begin
        mem_wr_en   = 1'b0;
        mem_wr_addr = i_w_addr;
        mem_wr_data = i_w_data;
        mem_wr_mask = i_w_wmask;
        if (state == ST_INIT) begin
            mem_wr_en   = 1'b1;
            mem_wr_addr = sweep_cnt;
            mem_wr_data = '0;
            mem_wr_mask = '1;
        end else begin
            mem_wr_en   = i_w_valid && !i_flush;
        end
    end

    assign mem_rd_en = (state == ST_RUN) && i_r_valid && !i_flush;

    status_array_mem #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_WAYS   (NUM_WAYS),
        .TAG_WIDTH  (TAG_WIDTH),
        .ROW_WIDTH  (ROW_WIDTH)
    ) u_mem (
        .clk       (clk),
        .arst_n    (arst_n),
        .halt      (i_halt),
        .rd_en     (mem_rd_en),
        .rd_addr   (i_r_addr),
        .rd_tag_in (i_tag),
        .wr_en     (mem_wr_en),
        .wr_addr   (mem_wr_addr),
        .wr_data   (mem_wr_data),
        .wr_mask   (mem_wr_mask),
        .rd_data   (o_data),
        .rd_tag    (o_tag),
        .rd_valid  (o_valid)
    );

endmodule

// File: tb/tb_status_array_ctrl.sv
// Self-checking bench for status_array_ctrl: default 16x4 instance driven
// through a read scoreboard, plus a 64x8 instance for sweep length checks.
module tb_status_array_ctrl;

    localparam int AW    = 4;
    localparam int NW    = 4;
    localparam int TW    = 1;
    localparam int RW    = 8;
    localparam int DEPTH = 16;

    localparam int AW_B    = 6;
    localparam int NW_B    = 8;
    localparam int RW_B    = 16;

    logic          clk = 1'b0;
    logic          arst_n;
    logic          i_halt;
    logic          i_flush;
    logic [TW-1:0] i_tag;
    logic [AW-1:0] i_r_addr;
    logic          i_r_valid;
    logic [AW-1:0] i_w_addr;
    logic [RW-1:0] i_w_data;
    logic [NW-1:0] i_w_wmask;
    logic          i_w_valid;
    logic [TW-1:0] o_tag;
    logic [RW-1:0] o_data;
    logic          o_valid;
    logic          o_ready;
    logic          o_init_busy;

    logic            arst_n_b;
    logic            i_r_valid_b;
    logic [AW_B-1:0] i_r_addr_b;
    logic [TW-1:0]   i_tag_b;
    logic            i_w_valid_b;
    logic [AW_B-1:0] i_w_addr_b;
    logic [RW_B-1:0] i_w_data_b;
    logic [NW_B-1:0] i_w_wmask_b;
    logic [TW-1:0]   o_tag_b;
    logic [RW_B-1:0] o_data_b;
    logic            o_valid_b;
    logic            o_ready_b;
    logic            o_init_busy_b;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [TW-1:0] tag;
        logic [RW-1:0] data;
    } resp_t;

    resp_t         exp_q[$];
    resp_t         mon_exp;
    logic [RW-1:0] model [DEPTH];
    logic          halt_q = 1'b0;

    always #5 clk = ~clk;

    status_array_ctrl #(
        .ADDR_WIDTH (AW),
        .NUM_WAYS   (NW),
        .TAG_WIDTH  (TW)
    ) dut (
        .clk         (clk),
        .arst_n      (arst_n),
        .i_halt      (i_halt),
        .i_flush     (i_flush),
        .i_tag       (i_tag),
        .i_r_addr    (i_r_addr),
        .i_r_valid   (i_r_valid),
        .i_w_addr    (i_w_addr),
        .i_w_data    (i_w_data),
        .i_w_wmask   (i_w_wmask),
        .i_w_valid   (i_w_valid),
        .o_tag       (o_tag),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .o_ready     (o_ready),
        .o_init_busy (o_init_busy)
    );

    status_array_ctrl #(
        .ADDR_WIDTH (AW_B),
        .NUM_WAYS   (NW_B),
        .TAG_WIDTH  (TW)
    ) dut_b (
        .clk         (clk),
        .arst_n      (arst_n_b),
        .i_halt      (1'b0),
        .i_flush     (1'b0),
        .i_tag       (i_tag_b),
        .i_r_addr    (i_r_addr_b),
        .i_r_valid   (i_r_valid_b),
        .i_w_addr    (i_w_addr_b),
        .i_w_data    (i_w_data_b),
        .i_w_wmask   (i_w_wmask_b),
        .i_w_valid   (i_w_valid_b),
        .o_tag       (o_tag_b),
        .o_data      (o_data_b),
        .o_valid     (o_valid_b),
        .o_ready     (o_ready_b),
        .o_init_busy (o_init_busy_b)
    );

    // Remember whether the last edge was halted so held responses are not re-popped.
    always @(posedge clk) halt_q = i_halt;

    // Scoreboard: every fresh response must match the oldest pending read.
    always @(negedge clk) begin
        if (arst_n && o_valid && !halt_q) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("[TB] FAIL sb_unexpected: got o_valid=1 (data=%h), required no response", o_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if (o_tag !== mon_exp.tag || o_data !== mon_exp.data) begin
                    failures++;
                    $display("[TB] FAIL sb_read: got tag=%h data=%h, required tag=%h data=%h",
                             o_tag, o_data, mon_exp.tag, mon_exp.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        i_halt    = 1'b0;
        i_flush   = 1'b0;
        i_r_valid = 1'b0;
        i_w_valid = 1'b0;
        i_w_wmask = '0;
    endtask

    task automatic clear_model();
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
    endtask

    task automatic drive_read(input logic [AW-1:0] a, input logic [TW-1:0] t);
        i_r_valid = 1'b1;
        i_r_addr  = a;
        i_tag     = t;
        exp_q.push_back({t, model[a]});
    endtask

    task automatic drive_write(input logic [AW-1:0] a, input logic [RW-1:0] d, input logic [NW-1:0] m);
        i_w_valid = 1'b1;
        i_w_addr  = a;
        i_w_data  = d;
        i_w_wmask = m;
        for (int w = 0; w < NW; w++) begin
            if (m[w]) model[a][2*w +: 2] = d[2*w +: 2];
        end
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (o_ready !== 1'b1 && n < 500) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_ready_b(output int n);
        n = 0;
        while (o_ready_b !== 1'b1 && n < 500) begin
            tick();
            n++;
        end
    endtask

    task automatic read_all_rows();
        for (int i = 0; i < DEPTH; i++) begin
            drive_read(AW'(i), 1'(i));
            tick();
        end
        idle();
        tick();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL sb_drain: got %0d pending reads, required 0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        int n;
        arst_n = 1'b0;
        idle();
        clear_model();
        tick();
        tick();
        checks++;
        if ({o_ready, o_init_busy, o_valid} !== 3'b010) begin
            failures++;
            $display("[TB] FAIL reset_flags: got ready/busy/valid=%b, required 010", {o_ready, o_init_busy, o_valid});
        end
        checks++;
        if (o_data !== '0 || o_tag !== '0) begin
            failures++;
            $display("[TB] FAIL reset_data: got data=%h tag=%h, required 0/0", o_data, o_tag);
        end
        arst_n = 1'b1;
        wait_ready(n);
        checks++;
        if (n != DEPTH || o_init_busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL init_len: got %0d cycles busy=%b, required %0d busy=0", n, o_init_busy, DEPTH);
        end
        read_all_rows();
    endtask

    task automatic test_masked_write();
        idle();
        drive_write(4'd3, 8'hFF, 4'b0101);
        tick();
        idle();
        drive_read(4'd3, 1'b1);
        tick();
        idle();
        checks++;
        if (o_valid !== 1'b1 || o_data !== 8'h33 || o_tag !== 1'b1) begin
            failures++;
            $display("[TB] FAIL masked_write: got valid=%b data=%h tag=%h, required 1/33/1", o_valid, o_data, o_tag);
        end
        tick();
        checks++;
        if (o_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL valid_pulse: got o_valid=%b, required 0", o_valid);
        end
    endtask

    task automatic test_rw_same_row();
        drive_read(4'd5, 1'b0);
        drive_write(4'd5, 8'hAA, 4'hF);
        tick();
        idle();
        checks++;
        if (o_data !== 8'h00) begin
            failures++;
            $display("[TB] FAIL rbw_old: got %h, required 00", o_data);
        end
        drive_read(4'd5, 1'b1);
        tick();
        idle();
        checks++;
        if (o_data !== 8'hAA) begin
            failures++;
            $display("[TB] FAIL rbw_new: got %h, required aa", o_data);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] ra;
        logic [AW-1:0] wa;
        for (int i = 0; i < 24; i++) begin
            ra = AW'($urandom_range(0, DEPTH - 1));
            wa = ra ^ AW'($urandom_range(1, DEPTH - 1));
            drive_read(ra, 1'($urandom));
            drive_write(wa, 8'($urandom), 4'($urandom));
            tick();
        end
        idle();
        for (int i = 0; i < DEPTH; i++) begin
            drive_read(AW'(i), 1'b0);
            tick();
        end
        idle();
        tick();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL b2b_drain: got %0d pending reads, required 0", exp_q.size());
        end
    endtask

    task automatic test_flush();
        int n;
        for (int i = 0; i < DEPTH; i++) begin
            drive_write(AW'(i), 8'(i * 13 + 7), 4'hF);
            tick();
        end
        idle();
        i_flush   = 1'b1;
        i_w_valid = 1'b1;
        i_w_addr  = 4'd2;
        i_w_data  = 8'hFF;
        i_w_wmask = 4'hF;
        i_r_valid = 1'b1;
        i_r_addr  = 4'd2;
        tick();
        idle();
        clear_model();
        checks++;
        if (o_ready !== 1'b0 || o_init_busy !== 1'b1 || o_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL flush_enter: got ready/busy/valid=%b%b%b, required 010", o_ready, o_init_busy, o_valid);
        end
        wait_ready(n);
        checks++;
        if (n != DEPTH) begin
            failures++;
            $display("[TB] FAIL flush_len: got %0d cycles, required %0d", n, DEPTH);
        end
        read_all_rows();
    endtask

    task automatic test_halt_init();
        int n;
        arst_n = 1'b0;
        idle();
        tick();
        arst_n = 1'b1;
        clear_model();
        repeat (2) tick();
        i_flush   = 1'b1;
        i_r_valid = 1'b1;
        i_r_addr  = 4'd0;
        tick();
        idle();
        repeat (4) tick();
        i_halt = 1'b1;
        repeat (3) tick();
        checks++;
        if (o_init_busy !== 1'b1 || o_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL halt_init_flags: got busy=%b ready=%b, required 1/0", o_init_busy, o_ready);
        end
        i_halt = 1'b0;
        wait_ready(n);
        checks++;
        if (n != DEPTH - 7) begin
            failures++;
            $display("[TB] FAIL halt_init_len: got %0d remaining cycles, required %0d", n, DEPTH - 7);
        end
    endtask

    task automatic test_halt_run();
        drive_write(4'd3, 8'h5A, 4'hF);
        tick();
        idle();
        drive_read(4'd3, 1'b1);
        tick();
        idle();
        i_halt    = 1'b1;
        i_flush   = 1'b1;
        i_w_valid = 1'b1;
        i_w_addr  = 4'd3;
        i_w_data  = 8'h00;
        i_w_wmask = 4'hF;
        i_r_valid = 1'b1;
        i_r_addr  = 4'd0;
        i_tag     = 1'b0;
        tick();
        tick();
        checks++;
        if (o_valid !== 1'b1 || o_data !== 8'h5A || o_tag !== 1'b1 || o_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL halt_hold: got valid=%b data=%h tag=%h ready=%b, required 1/5a/1/1",
                     o_valid, o_data, o_tag, o_ready);
        end
        idle();
        tick();
        checks++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL halt_release: got valid=%b ready=%b, required 0/1", o_valid, o_ready);
        end
        drive_read(4'd3, 1'b0);
        tick();
        idle();
        checks++;
        if (o_data !== 8'h5A) begin
            failures++;
            $display("[TB] FAIL halt_no_write: got %h, required 5a", o_data);
        end
        tick();
    endtask

    task automatic test_reset_midsweep();
        int n;
        #2;
        arst_n = 1'b0;
        #1;
        checks++;
        if (o_ready !== 1'b0 || o_init_busy !== 1'b1 || o_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL async_reset: got ready/busy/valid=%b%b%b, required 010", o_ready, o_init_busy, o_valid);
        end
        idle();
        tick();
        arst_n = 1'b1;
        repeat (9) tick();
        arst_n = 1'b0;
        tick();
        arst_n = 1'b1;
        clear_model();
        wait_ready(n);
        checks++;
        if (n != DEPTH) begin
            failures++;
            $display("[TB] FAIL midsweep_restart: got %0d cycles, required %0d", n, DEPTH);
        end
    endtask

    task automatic test_wide_config();
        int n;
        arst_n_b = 1'b0;
        tick();
        arst_n_b = 1'b1;
        wait_ready_b(n);
        checks++;
        if (n != 64) begin
            failures++;
            $display("[TB] FAIL wide_init_len: got %0d cycles, required 64", n);
        end
        arst_n_b = 1'b0;
        tick();
        arst_n_b = 1'b1;
        repeat (9) tick();
        arst_n_b = 1'b0;
        tick();
        arst_n_b = 1'b1;
        wait_ready_b(n);
        checks++;
        if (n != 64) begin
            failures++;
            $display("[TB] FAIL wide_restart_len: got %0d cycles, required 64", n);
        end
        i_w_valid_b = 1'b1;
        i_w_addr_b  = 6'd63;
        i_w_data_b  = 16'hFFFF;
        i_w_wmask_b = 8'b1000_0001;
        i_r_valid_b = 1'b1;
        i_r_addr_b  = 6'd63;
        i_tag_b     = 1'b1;
        tick();
        i_w_valid_b = 1'b0;
        checks++;
        if (o_valid_b !== 1'b1 || o_data_b !== 16'h0000 || o_tag_b !== 1'b1) begin
            failures++;
            $display("[TB] FAIL wide_read_zero: got valid=%b data=%h tag=%h, required 1/0000/1", o_valid_b, o_data_b, o_tag_b);
        end
        i_tag_b = 1'b0;
        tick();
        i_r_valid_b = 1'b0;
        checks++;
        if (o_data_b !== 16'hC003 || o_tag_b !== 1'b0) begin
            failures++;
            $display("[TB] FAIL wide_masked: got data=%h tag=%h, required c003/0", o_data_b, o_tag_b);
        end
        tick();
    endtask

    // Watchdog so a stuck design still ends the run.
    initial begin
        #1000000;
        $display("[TB] FAIL timeout: simulation did not finish, required completion");
        $fatal(1, "[TB] timeout");
    end

    // Test sequence.
    initial begin
        arst_n      = 1'b0;
        arst_n_b    = 1'b0;
        i_tag       = '0;
        i_r_addr    = '0;
        i_w_addr    = '0;
        i_w_data    = '0;
        i_r_valid_b = 1'b0;
        i_r_addr_b  = '0;
        i_tag_b     = '0;
        i_w_valid_b = 1'b0;
        i_w_addr_b  = '0;
        i_w_data_b  = '0;
        i_w_wmask_b = '0;
        idle();
        $display("[TB] starting");
        test_reset();
        test_masked_write();
        test_rw_same_row();
        test_back_to_back();
        test_flush();
        test_halt_run();
        test_halt_init();
        test_reset_midsweep();
        test_wide_config();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL final_drain: got %0d pending reads, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
